// File: rtl/gmsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gmsk_pkg
// Description : Shared GMSK constants, receiver state encoding and a
//               constant-foldable ceil(log2) helper used to size counters
//               and accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
package gmsk_pkg;

    // Shared with the transmit side: modulator output width and ROM index.
    localparam int GMSK_SAMPLE_BITS    = 8;
    localparam int GMSK_ROM_INDEX_BITS = 7;

    // Carrier-detect states.
    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } gmsk_rx_state_e;

    // ceil(log2(value)); clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gmsk_diff_detector.sv
`default_nettype none
// ============================================================================
// Module      : gmsk_diff_detector
// Description : Sample pipeline stages S1-S2 of the GMSK receiver.
//               S1 holds the current and previous I/Q sample; S2 registers
//               the differential-phase cross product
//                   P = Q[n]*I[n-1] - I[n]*Q[n-1]
//               and the sample magnitude estimate E = |I[n]| + |Q[n]|.
//               Both stages advance only on sample_strobe_i.
// Ports       : clock, reset          - clock, synchronous active-high reset
//               sample_strobe_i       - advances the pipeline
//               inphase_i/quadrature_i- signed I/Q sample
//               prod_o                - signed P, 2*SAMPLE_BITS+1 bits
//               energy_o              - unsigned E, SAMPLE_BITS+1 bits
//               valid_o               - prod_o/energy_o hold a real sample
// Revision    : 1.0 - initial release
// ============================================================================
module gmsk_diff_detector
    import gmsk_pkg::*;
#(
    parameter int SAMPLE_BITS = GMSK_SAMPLE_BITS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sample_strobe_i,
    input  logic signed [SAMPLE_BITS-1:0] inphase_i,
    input  logic signed [SAMPLE_BITS-1:0] quadrature_i,
    output logic signed [2*SAMPLE_BITS:0] prod_o,
    output logic        [SAMPLE_BITS:0]   energy_o,
    output logic                          valid_o
);

    localparam int c_prod_w = 2 * SAMPLE_BITS + 1;
    localparam int c_ext_w  = c_prod_w - SAMPLE_BITS;

    // S1 registers
    logic signed [SAMPLE_BITS-1:0] i_cur_q, q_cur_q, i_prev_q, q_prev_q;
    logic                          cur_valid_q, prev_valid_q;

    // S2 registers
    logic signed [c_prod_w-1:0]    prod_q;
    logic        [SAMPLE_BITS:0]   energy_q;
    logic                          valid_q;

    // Combinational S2 inputs
    logic signed [c_prod_w-1:0]    w_i_cur, w_q_cur, w_i_prev, w_q_prev;
    logic signed [c_prod_w-1:0]    w_cross_a, w_cross_b;
    logic signed [c_prod_w-1:0]    prod_d;
    logic signed [SAMPLE_BITS:0]   w_i_ext, w_q_ext;
    logic        [SAMPLE_BITS:0]   w_i_abs, w_q_abs;
    logic        [SAMPLE_BITS:0]   energy_d;

    assign w_i_cur  = {{c_ext_w{i_cur_q[SAMPLE_BITS-1]}},  i_cur_q};
    assign w_q_cur  = {{c_ext_w{q_cur_q[SAMPLE_BITS-1]}},  q_cur_q};
    assign w_i_prev = {{c_ext_w{i_prev_q[SAMPLE_BITS-1]}}, i_prev_q};
    assign w_q_prev = {{c_ext_w{q_prev_q[SAMPLE_BITS-1]}}, q_prev_q};

    assign w_cross_a = w_q_cur * w_i_prev;
    assign w_cross_b = w_i_cur * w_q_prev;

    // Without a genuine predecessor the cross product is meaningless.
    assign prod_d = prev_valid_q ? (w_cross_a - w_cross_b) : '0;

    // One extra bit so that the most negative input negates to a positive.
    assign w_i_ext  = {i_cur_q[SAMPLE_BITS-1], i_cur_q};
    assign w_q_ext  = {q_cur_q[SAMPLE_BITS-1], q_cur_q};
    assign w_i_abs  = w_i_ext[SAMPLE_BITS] ? (-w_i_ext) : w_i_ext;
    assign w_q_abs  = w_q_ext[SAMPLE_BITS] ? (-w_q_ext) : w_q_ext;
    assign energy_d = w_i_abs + w_q_abs;

    always_ff @(posedge clock) begin
        if (reset) begin
            i_cur_q      <= '0;
            q_cur_q      <= '0;
            i_prev_q     <= '0;
            q_prev_q     <= '0;
            cur_valid_q  <= 1'b0;
            prev_valid_q <= 1'b0;
            prod_q       <= '0;
            energy_q     <= '0;
            valid_q      <= 1'b0;
        end else if (sample_strobe_i) begin
            i_prev_q     <= i_cur_q;
            q_prev_q     <= q_cur_q;
            i_cur_q      <= inphase_i;
            q_cur_q      <= quadrature_i;
            prev_valid_q <= cur_valid_q;
            cur_valid_q  <= 1'b1;
            prod_q       <= prod_d;
            energy_q     <= energy_d;
            valid_q      <= cur_valid_q;
        end
    end

    assign prod_o   = prod_q;
    assign energy_o = energy_q;
    assign valid_o  = valid_q;

endmodule
`default_nettype wire

// File: rtl/gmsk_rx.sv
`default_nettype none
// ============================================================================
// Module      : gmsk_rx
// Description : GMSK demodulator. A differential-phase detector feeds an
//               integrate-and-dump accumulator; on each symbol strobe the
//               sum is sliced to a bit. A carrier-detect FSM (HUNT/LOCKED)
//               driven by per-symbol energy gates the bit output.
// Ports       : clock, reset           - clock, synchronous active-high reset
//               sample_strobe          - I/Q sample valid this cycle
//               symbol_strobe          - symbol boundary (dump/slice)
//               inphase_in/quadrature_in - signed I/Q samples
//               rx_bit, rx_bit_valid   - sliced bit and its 1-cycle qualifier
//               carrier_detect         - high while LOCKED
//               rx_soft                - (optional) saturated soft decision
// Options     : GMSK_RX_SOFT_OUT_EN adds rx_soft, the top 8 bits of the
//               dumped accumulator saturated to [-127,+127].
// Revision    : 1.0 - initial release
// ============================================================================
module gmsk_rx
    import gmsk_pkg::*;
#(
    parameter int SAMPLE_BITS            = GMSK_SAMPLE_BITS,
    parameter int MAX_SAMPLES_PER_SYMBOL = 128,
    parameter int ENERGY_THRESHOLD       = 2000,
    parameter int LOCK_SYMBOLS           = 4,
    parameter int LOSS_SYMBOLS           = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sample_strobe,
    input  logic                          symbol_strobe,
    input  logic signed [SAMPLE_BITS-1:0] inphase_in,
    input  logic signed [SAMPLE_BITS-1:0] quadrature_in,
    output logic                          rx_bit,
    output logic                          rx_bit_valid,
`ifdef GMSK_RX_SOFT_OUT_EN
    output logic signed [7:0]             rx_soft,
`endif
    output logic                          carrier_detect
);

    localparam int c_prod_w  = 2 * SAMPLE_BITS + 1;
    localparam int c_en_w    = SAMPLE_BITS + 1;
    localparam int c_cnt_log = clog2(MAX_SAMPLES_PER_SYMBOL);
    localparam int c_acc_w   = c_prod_w + c_cnt_log;
    localparam int c_eacc_w  = c_en_w + c_cnt_log;
    localparam int c_sym_max = (LOCK_SYMBOLS > LOSS_SYMBOLS) ? LOCK_SYMBOLS : LOSS_SYMBOLS;
    localparam int c_cnt_w   = clog2(c_sym_max + 1);

    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_SYMBOLS - 1);
    localparam logic [c_cnt_w-1:0] c_loss_last = c_cnt_w'(LOSS_SYMBOLS - 1);

    // ------------------------------------------------------------------
    // S1-S2: differential-phase detector
    // ------------------------------------------------------------------
    logic signed [c_prod_w-1:0] w_det_prod;
    logic        [c_en_w-1:0]   w_det_energy;
    logic                       w_det_valid;

    gmsk_diff_detector #(
        .SAMPLE_BITS (SAMPLE_BITS)
    ) u_diff_detector (
        .clock           (clock),
        .reset           (reset),
        .sample_strobe_i (sample_strobe),
        .inphase_i       (inphase_in),
        .quadrature_i    (quadrature_in),
        .prod_o          (w_det_prod),
        .energy_o        (w_det_energy),
        .valid_o         (w_det_valid)
    );

    // ------------------------------------------------------------------
    // S3: integrate and dump
    // ------------------------------------------------------------------
    logic signed [c_acc_w-1:0]  acc_q, acc_d;
    logic        [c_eacc_w-1:0] eacc_q, eacc_d;
    logic signed [c_acc_w-1:0]  w_prod_ext;
    logic        [c_eacc_w-1:0] w_energy_ext;
    logic                       w_accum;
    logic                       w_energetic;
    logic                       w_slice;

    assign w_accum      = sample_strobe & w_det_valid;
    assign w_prod_ext   = {{(c_acc_w - c_prod_w){w_det_prod[c_prod_w-1]}}, w_det_prod};
    assign w_energy_ext = {{(c_eacc_w - c_en_w){1'b0}}, w_det_energy};

    // A contribution arriving in the dump cycle seeds the next symbol.
    always_comb begin
        acc_d  = acc_q;
        eacc_d = eacc_q;
        if (symbol_strobe) begin
            acc_d  = w_accum ? w_prod_ext   : '0;
            eacc_d = w_accum ? w_energy_ext : '0;
        end else if (w_accum) begin
            acc_d  = acc_q + w_prod_ext;
            eacc_d = eacc_q + w_energy_ext;
        end
    end

    // Decisions use the pre-dump sums; acc == 0 slices to 0.
    assign w_slice     = ~acc_q[c_acc_w-1] & (|acc_q);
    assign w_energetic = (32'(eacc_q) >= 32'(ENERGY_THRESHOLD));

    // ------------------------------------------------------------------
    // Carrier-detect state machine
    // ------------------------------------------------------------------
    gmsk_rx_state_e     state_q, state_d;
    logic [c_cnt_w-1:0] run_cnt_q, run_cnt_d;
    logic [c_cnt_w-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (symbol_strobe) begin
            case (state_q)
                HUNT: begin
                    if (w_energetic) begin
                        if (run_cnt_q == c_lock_last) begin
                            state_d    = LOCKED;
                            run_cnt_d  = '0;
                            miss_cnt_d = '0;
                        end else begin
                            run_cnt_d = run_cnt_q + 1'b1;
                        end
                    end else begin
                        run_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (!w_energetic) begin
                        if (miss_cnt_q == c_loss_last) begin
                            state_d    = HUNT;
                            run_cnt_d  = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = HUNT;
                    run_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic rx_bit_q, rx_bit_d;
    logic rx_bit_valid_q, rx_bit_valid_d;
    logic carrier_q, carrier_d;

    assign rx_bit_d       = symbol_strobe ? w_slice : rx_bit_q;
    // Gate on the state the decision was made in, so the locking symbol
    // itself is never emitted.
    assign rx_bit_valid_d = symbol_strobe & (state_q == LOCKED);
    assign carrier_d      = (state_d == LOCKED);

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q          <= '0;
            eacc_q         <= '0;
            state_q        <= HUNT;
            run_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            rx_bit_q       <= 1'b0;
            rx_bit_valid_q <= 1'b0;
            carrier_q      <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            eacc_q         <= eacc_d;
            state_q        <= state_d;
            run_cnt_q      <= run_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_bit_valid_q <= rx_bit_valid_d;
            carrier_q      <= carrier_d;
        end
    end

    assign rx_bit         = rx_bit_q;
    assign rx_bit_valid   = rx_bit_valid_q;
    assign carrier_detect = carrier_q;

`ifdef GMSK_RX_SOFT_OUT_EN
    // Soft decision: top byte of the dumped sum, symmetric range.
    logic signed [7:0] soft_q, soft_d;
    logic signed [7:0] w_soft_top;

    assign w_soft_top = acc_q[c_acc_w-1 -: 8];

    always_comb begin
        soft_d = soft_q;
        if (symbol_strobe) begin
            soft_d = (w_soft_top == 8'sh80) ? 8'sh81 : w_soft_top;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            soft_q <= '0;
        end else begin
            soft_q <= soft_d;
        end
    end

    assign rx_soft = soft_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gmsk_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmsk_rx
// Description : Self-checking bench for gmsk_rx. Directed I/Q symbols are
//               generated on a four-point diagonal constellation (90 deg per
//               sample, P = +/-2*a^2, E = 2*a per sample). Expected bits are
//               queued as each symbol strobe is issued; a monitor pops and
//               compares on every rx_bit_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmsk_rx;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              sample_strobe = 1'b0;
    logic              symbol_strobe = 1'b0;
    logic signed [7:0] inphase_in = '0;
    logic signed [7:0] quadrature_in = '0;
    logic              rx_bit;
    logic              rx_bit_valid;
    logic              carrier_detect;
`ifdef GMSK_RX_SOFT_OUT_EN
    logic signed [7:0] rx_soft;
`endif

    localparam logic signed [7:0] c_neg_full = 8'sh80;

    gmsk_rx dut (
        .clock          (clock),
        .reset          (reset),
        .sample_strobe  (sample_strobe),
        .symbol_strobe  (symbol_strobe),
        .inphase_in     (inphase_in),
        .quadrature_in  (quadrature_in),
        .rx_bit         (rx_bit),
        .rx_bit_valid   (rx_bit_valid),
`ifdef GMSK_RX_SOFT_OUT_EN
        .rx_soft        (rx_soft),
`endif
        .carrier_detect (carrier_detect)
    );

    always #5 clock = ~clock;

    int   tests = 0;
    int   fails = 0;
    int   ph    = 0;
    bit   exp_q[$];
    logic exp_bit;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (rx_bit_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: rx_bit=%0b got a pulse, required none", rx_bit);
            end else begin
                exp_bit = exp_q.pop_front();
                if (rx_bit !== exp_bit) begin
                    fails++;
                    $display("FAIL rx_bit: got %0b required %0b", rx_bit, exp_bit);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic cycle(input logic ss, input logic sy,
                         input logic signed [7:0] i, input logic signed [7:0] q);
        sample_strobe = ss;
        symbol_strobe = sy;
        inphase_in    = i;
        quadrature_in = q;
        @(posedge clock);
        #1;
        sample_strobe = 1'b0;
        symbol_strobe = 1'b0;
    endtask

    function automatic logic signed [7:0] diag_i(input int p, input int a);
        return (p == 1 || p == 2) ? 8'(-a) : 8'(a);
    endfunction

    function automatic logic signed [7:0] diag_q(input int p, input int a);
        return (p >= 2) ? 8'(-a) : 8'(a);
    endfunction

    // n samples rotating by dir (+1 CCW, -1 CW, 0 hold), then a strobe-only
    // cycle. exp < 0 means no bit is expected for this symbol.
    task automatic rot_symbol(input int n, input int dir, input int amp, input int exp);
        for (int k = 0; k < n; k++) begin
            ph = (ph + dir) & 3;
            cycle(1'b1, 1'b0, diag_i(ph, amp), diag_q(ph, amp));
        end
        if (exp >= 0) exp_q.push_back(exp[0]);
        cycle(1'b0, 1'b1, 8'sd0, 8'sd0);
    endtask

    task automatic const_symbol(input int n, input logic signed [7:0] i,
                                input logic signed [7:0] q, input int exp);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, i, q);
        if (exp >= 0) exp_q.push_back(exp[0]);
        cycle(1'b0, 1'b1, 8'sd0, 8'sd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) cycle(k[0], k[0], 8'sd55, -8'sd20);
        reset = 1'b0;
    endtask

    initial begin
        // ---- reset state, strobes toggling ----
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 8'sd100, 8'sd100);
            check("reset_valid", rx_bit_valid, 0);
        end
        check("reset_bit", rx_bit, 0);
        check("reset_carrier", carrier_detect, 0);
        reset = 1'b0;

        // ---- lock on CCW (first symbol energy exactly 2000) and decode 1s ----
        for (int s = 1; s <= 3; s++) rot_symbol(12, 1, 100, -1);
        check("carrier_before_lock", carrier_detect, 0);
        rot_symbol(12, 1, 100, -1);
        check("carrier_at_lock", carrier_detect, 1);
        for (int s = 5; s <= 10; s++) rot_symbol(12, 1, 100, 1);

        // ---- CW gives 0s, then alternation ----
        for (int s = 0; s < 3; s++) rot_symbol(12, -1, 100, 0);
        for (int s = 0; s < 6; s++) begin
            if (s % 2 == 0) rot_symbol(12, 1, 100, 1);
            else            rot_symbol(12, -1, 100, 0);
        end

        // ---- loss of lock ----
        for (int s = 0; s < 7; s++) rot_symbol(12, 0, 0, 0);
        check("locked_after_7_miss", carrier_detect, 1);
        rot_symbol(12, 1, 100, 1);
        rot_symbol(12, 0, 0, 1);
        for (int s = 0; s < 6; s++) rot_symbol(12, 0, 0, 0);
        check("locked_after_7_miss_b", carrier_detect, 1);
        rot_symbol(12, 0, 0, 0);
        check("unlocked_after_8_miss", carrier_detect, 0);

        // ---- noise gating: eacc = 16 per symbol ----
        for (int s = 0; s < 20; s++) rot_symbol(4, 1, 2, -1);
        check("noise_carrier", carrier_detect, 0);

        // ---- reset mid-symbol ----
        do_reset(2);
        for (int s = 0; s < 4; s++) rot_symbol(12, 1, 100, -1);
        check("relock_carrier", carrier_detect, 1);
        rot_symbol(12, 1, 100, 1);
        for (int k = 0; k < 6; k++) begin
            ph = (ph + 3) & 3;
            cycle(1'b1, 1'b0, diag_i(ph, 100), diag_q(ph, 100));
        end
        reset = 1'b1;
        cycle(1'b1, 1'b1, 8'sd100, 8'sd100);
        check("midreset_valid", rx_bit_valid, 0);
        check("midreset_bit", rx_bit, 0);
        check("midreset_carrier", carrier_detect, 0);
        cycle(1'b0, 1'b0, 8'sd0, 8'sd0);
        reset = 1'b0;
        rot_symbol(11, 1, 100, -1);   // 9 contributions: 1800, not energetic
        for (int s = 0; s < 3; s++) rot_symbol(12, 1, 100, -1);
        check("no_stale_energy", carrier_detect, 0);
        rot_symbol(12, 1, 100, -1);
        check("lock_after_reset", carrier_detect, 1);
        rot_symbol(12, 1, 100, 1);

        // ---- full-scale negative inputs: E = 256, P = 0 ----
        do_reset(2);
        for (int s = 0; s < 4; s++) const_symbol(8, c_neg_full, c_neg_full, -1);
        check("neg_full_before_lock", carrier_detect, 0);
        const_symbol(8, c_neg_full, c_neg_full, -1);
        check("neg_full_lock", carrier_detect, 1);
        const_symbol(8, c_neg_full, c_neg_full, 0);

        // ---- symbol strobe coincident with an accumulate ----
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, c_neg_full, c_neg_full);
        cycle(1'b1, 1'b0, 8'sd0, c_neg_full);   // P = +16384
        cycle(1'b1, 1'b0, 8'sd0, c_neg_full);
        exp_q.push_back(1'b0);
        cycle(1'b1, 1'b1, 8'sd0, c_neg_full);   // the +16384 lands here
        const_symbol(8, 8'sd0, c_neg_full, 1);
        const_symbol(8, 8'sd0, c_neg_full, 0);
        check("coincident_still_locked", carrier_detect, 1);

        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 8'sd0, 8'sd0);
        check("pending_bits", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
